// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if: request/done inputs and grant/select/busy outputs of the two-way arbiter
interface mux_sel_arbiter_if;
  logic i_req_a, i_req_b, i_done, o_gnt_a, o_gnt_b, o_sel, o_busy;
  modport master(output i_req_a, i_req_b, i_done, input o_gnt_a, o_gnt_b, o_sel, o_busy);
  modport slave(input i_req_a, i_req_b, i_done, output o_gnt_a, o_gnt_b, o_sel, o_busy);
endinterface

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-requester path arbiter (i_clk, async i_rst, bus: req_a/req_b/done in, gnt_a/gnt_b/sel/busy out)
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input logic i_clk,
  input logic i_rst,
  mux_sel_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, SWITCH} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic mine, other, rel, full, last_a;
  // o_sel only moves on OWN entry, so it doubles as the last-granted pointer
  assign last_a = bus.o_sel;
  always_comb begin
    mine = state == OWN_A ? bus.i_req_a : bus.i_req_b;
    other = state == OWN_A ? bus.i_req_b : bus.i_req_a;
    rel = bus.i_done || !mine;
    full = cnt == 8'(HOLD_MAX - 1);
    nxt = state;
    case (state)
      IDLE: nxt = bus.i_req_a && bus.i_req_b ? (last_a ? OWN_B : OWN_A) :
                  bus.i_req_a ? OWN_A : bus.i_req_b ? OWN_B : IDLE;
      OWN_A, OWN_B: nxt = (rel || full) && other ? SWITCH : rel ? IDLE : state;
      SWITCH: nxt = last_a ? (bus.i_req_b ? OWN_B : IDLE) : (bus.i_req_a ? OWN_A : IDLE);
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.o_gnt_a <= 1'b0;
      bus.o_gnt_b <= 1'b0;
      bus.o_sel <= 1'b0;
      bus.o_busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : full ? cnt : cnt + 8'd1;
      bus.o_gnt_a <= nxt == OWN_A;
      bus.o_gnt_b <= nxt == OWN_B;
      bus.o_sel <= nxt == OWN_A ? 1'b1 : nxt == OWN_B ? 1'b0 : bus.o_sel;
      bus.o_busy <= nxt != IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(bus.o_gnt_a && bus.o_gnt_b)) else $error("grants not exclusive");
      assert (!(bus.o_gnt_a && !bus.o_sel) && !(bus.o_gnt_b && bus.o_sel)) else $error("sel/grant mismatch");
      assert (!$isunknown(bus.o_sel)) else $error("sel unknown");
    end
  end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed and random checks of mux_sel_arbiter against a behavioural model
module tb_mux_sel_arbiter;
  localparam int H = 4;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, failures = 0;
  int owner, turn, held, m_sel;
  mux_sel_arbiter_if bus ();
  mux_sel_arbiter #(.HOLD_MAX(H)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic model_reset();
    owner = 0;
    turn = 0;
    held = 0;
    m_sel = 0;
  endtask
  task automatic grant(input int side);
    owner = side;
    held = 0;
    m_sel = side == 1 ? 1 : 0;
  endtask
  task automatic model_step(input logic a, input logic b, input logic d);
    int tgt;
    logic rel, oth;
    if (turn != 0) begin
      tgt = turn;
      turn = 0;
      if (tgt == 1 ? a : b) grant(tgt);
      else owner = 0;
    end else if (owner == 0) begin
      if (a && b) grant(m_sel == 1 ? 2 : 1);
      else if (a) grant(1);
      else if (b) grant(2);
    end else begin
      rel = d || !(owner == 1 ? a : b);
      oth = owner == 1 ? b : a;
      if ((rel || held >= H - 1) && oth) begin
        turn = 3 - owner;
        owner = 0;
      end else if (rel) owner = 0;
      else held++;
    end
  endtask
  task automatic cmp_model(input string tag);
    chk({tag, "_gnt_a"}, 32'(bus.o_gnt_a), 32'(owner == 1));
    chk({tag, "_gnt_b"}, 32'(bus.o_gnt_b), 32'(owner == 2));
    chk({tag, "_sel"}, 32'(bus.o_sel), 32'(m_sel));
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'(owner != 0 || turn != 0));
  endtask
  task automatic step(input logic a, input logic b, input logic d, input string tag);
    bus.i_req_a = a;
    bus.i_req_b = b;
    bus.i_done = d;
    @(posedge clk);
    model_step(a, b, d);
    #1;
    cmp_model(tag);
  endtask
  task automatic do_reset(input logic a, input logic b);
    bus.i_req_a = a;
    bus.i_req_b = b;
    bus.i_done = 1'b0;
    rst = 1'b1;
    #3;
    chk("rst_gnt_a", 32'(bus.o_gnt_a), 0);
    chk("rst_gnt_b", 32'(bus.o_gnt_b), 0);
    chk("rst_sel", 32'(bus.o_sel), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    model_reset();
    rst = 1'b0;
  endtask
  initial begin
    logic a, b;
    bus.i_req_a = 1'b0;
    bus.i_req_b = 1'b0;
    bus.i_done = 1'b0;
    model_reset();
    do_reset(1, 1);
    step(1, 1, 0, "tie1");
    chk("tie_first_a", 32'({bus.o_gnt_a, bus.o_sel}), 32'b11);
    for (int i = 0; i < 3; i++) step(1, 1, 0, "tie_hold");
    chk("hold_still_a", 32'(bus.o_gnt_a), 1);
    step(1, 1, 0, "tie_sw");
    chk("switch_gaps", 32'({bus.o_gnt_a, bus.o_gnt_b, bus.o_sel}), 32'b001);
    step(1, 1, 0, "tie_b");
    chk("handover_b", 32'({bus.o_gnt_b, bus.o_sel}), 32'b10);
    do_reset(0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, "solo_b");
      chk("solo_b_held", 32'(bus.o_gnt_b), 1);
    end
    do_reset(0, 0);
    step(1, 0, 0, "done_own");
    step(1, 0, 1, "done_rel");
    chk("done_idle", 32'(bus.o_busy), 0);
    step(0, 1, 0, "done_b");
    chk("done_then_b", 32'(bus.o_gnt_b), 1);
    do_reset(0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, "both_own");
    step(1, 1, 1, "both_sw");
    chk("both_switch", 32'({bus.o_gnt_a, bus.o_gnt_b, bus.o_busy}), 32'b001);
    step(1, 1, 0, "both_b");
    chk("both_then_b", 32'(bus.o_gnt_b), 1);
    do_reset(0, 0);
    step(1, 1, 0, "drop_own");
    step(1, 1, 1, "drop_sw");
    step(1, 0, 0, "drop_idle");
    chk("drop_sel_kept", 32'({bus.o_sel, bus.o_busy}), 32'b10);
    do_reset(0, 0);
    step(0, 1, 0, "mid_own");
    #2 rst = 1'b1;
    #1;
    chk("async_gnt_b", 32'(bus.o_gnt_b), 0);
    chk("async_sel", 32'(bus.o_sel), 0);
    model_reset();
    #2 rst = 1'b0;
    a = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(a, b);
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      step(a, b, $urandom_range(0, 7) == 0, "rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
